life_engine: RTL

Parametrised cellular-automaton core: holds a 2^LOG_W x 2^LOG_H single-bit board, evolves it one generation per trigger under a programmable outer-totalistic birth/survive rule, and serves one cell per cycle to the VGA pixel path. It is the next-generation board engine between the control inputs (`ui_in`) and the display logic. Over the fixed 64x32 Conway engine it adds:
- configurable size;
- selectable torus or dead-edge boundary;
- single-step mode;
- a host write port;
- a generation counter.

---
 rtl/life_engine.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/life_engine.sv
// life_engine: outer-totalistic cellular automaton on a 2^LOG_W x 2^LOG_H single-bit board.
// One generation per trigger (9 cycles/cell evolve, 1 cycle/cell copy); one display read per cycle.
module life_engine #(
    parameter int unsigned LOG_W      = 6,
    parameter int unsigned LOG_H      = 5,
    parameter int unsigned UPDATE_DIV = 2400000,
    parameter logic [15:0] SEED       = 16'hACE1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             run_i,
    input  logic             step_i,
    input  logic             randomize_i,
    input  logic             frame_sync_i,
    input  logic             wrap_en_i,
    input  logic [8:0]       birth_mask_i,
    input  logic [8:0]       survive_mask_i,
    input  logic             wr_en_i,
    input  logic [LOG_W-1:0] wr_x_i,
    input  logic [LOG_H-1:0] wr_y_i,
    input  logic             wr_data_i,
    input  logic [LOG_W-1:0] rd_x_i,
    input  logic [LOG_H-1:0] rd_y_i,
    output logic             rd_cell_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [15:0]      gen_count_o
);
    localparam int unsigned IdxW   = LOG_W + LOG_H;
    localparam int unsigned N      = 1 << IdxW;
    localparam int unsigned TimerW = $clog2(UPDATE_DIV + 1);
    localparam logic [TimerW-1:0] TimerMax = TimerW'(UPDATE_DIV - 1);
    localparam logic [IdxW-1:0]   LastIdx  = {IdxW{1'b1}};

    typedef enum logic [1:0] {StIdle, StInit, StUpdate, StCopy} state_e;

    state_e            state_q, state_d;
    logic [IdxW-1:0]   idx_q, idx_d;
    logic [3:0]        phase_q, phase_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [TimerW-1:0] timer_q, timer_d;
    logic [15:0]       gen_q, gen_d;
    logic [15:0]       lfsr_q;
    logic              wrap_q, wrap_d;
    logic [8:0]        birth_q, birth_d, survive_q, survive_d;
    logic              rd_q;
    logic [N-1:0]      cur_q, nxt_q;

    logic            cur_we, nxt_we, cur_wdata, nxt_wdata;
    logic [IdxW-1:0] cur_waddr;
    logic            auto_trig, ncell, oob;
    logic [15:0]     birth_ext, survive_ext;

    logic [LOG_W-1:0] x, xm, xp, nx;
    logic [LOG_H-1:0] y, ym, yp, ny;
    logic             x_lo, x_hi, y_lo, y_hi;

    assign x    = idx_q[LOG_W-1:0];
    assign y    = idx_q[IdxW-1:LOG_W];
    assign xm   = x - LOG_W'(1);
    assign xp   = x + LOG_W'(1);
    assign ym   = y - LOG_H'(1);
    assign yp   = y + LOG_H'(1);
    assign x_lo = (x == '0);
    assign x_hi = (x == {LOG_W{1'b1}});
    assign y_lo = (y == '0);
    assign y_hi = (y == {LOG_H{1'b1}});

    // Neighbour visited in sub-cycle phase_q[2:0]; modular arithmetic gives the torus for free.
    always_comb begin
        nx  = x;
        ny  = y;
        oob = 1'b0;
        unique case (phase_q[2:0])
            3'd0: begin nx = xm; ny = yp; oob = x_lo | y_hi; end
            3'd1: begin nx = x;  ny = yp; oob = y_hi;        end
            3'd2: begin nx = xp; ny = yp; oob = x_hi | y_hi; end
            3'd3: begin nx = xm; ny = y;  oob = x_lo;        end
            3'd4: begin nx = xp; ny = y;  oob = x_hi;        end
            3'd5: begin nx = xm; ny = ym; oob = x_lo | y_lo; end
            3'd6: begin nx = x;  ny = ym; oob = y_lo;        end
            3'd7: begin nx = xp; ny = ym; oob = x_hi | y_lo; end
        endcase
    end

    assign ncell       = cur_q[{ny, nx}] & (wrap_q | ~oob);
    assign birth_ext   = {7'b0, birth_q};
    assign survive_ext = {7'b0, survive_q};
    assign auto_trig   = run_i & (timer_q == TimerMax) & frame_sync_i;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        phase_d   = phase_q;
        cnt_d     = cnt_q;
        timer_d   = timer_q;
        gen_d     = gen_q;
        wrap_d    = wrap_q;
        birth_d   = birth_q;
        survive_d = survive_q;
        cur_we    = 1'b0;
        cur_waddr = idx_q;
        cur_wdata = 1'b0;
        nxt_we    = 1'b0;
        nxt_wdata = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (wr_en_i) begin
                    cur_we    = 1'b1;
                    cur_waddr = {wr_y_i, wr_x_i};
                    cur_wdata = wr_data_i;
                end
                if (run_i && timer_q != TimerMax) timer_d = timer_q + TimerW'(1);
                if (step_i || auto_trig) begin
                    state_d   = randomize_i ? StInit : StUpdate;
                    timer_d   = '0;
                    idx_d     = '0;
                    phase_d   = '0;
                    cnt_d     = '0;
                    wrap_d    = wrap_en_i;
                    birth_d   = birth_mask_i;
                    survive_d = survive_mask_i;
                end
            end
            StInit: begin
                cur_we    = 1'b1;
                cur_wdata = lfsr_q[0];
                gen_d     = '0;
                idx_d     = idx_q + IdxW'(1);
                if (idx_q == LastIdx) state_d = StIdle;
            end
            StUpdate: begin
                if (phase_q == 4'd8) begin
                    nxt_we    = 1'b1;
                    nxt_wdata = cur_q[idx_q] ? survive_ext[cnt_q] : birth_ext[cnt_q];
                    cnt_d     = '0;
                    phase_d   = '0;
                    idx_d     = idx_q + IdxW'(1);
                    if (idx_q == LastIdx) state_d = StCopy;
                end else begin
                    cnt_d   = cnt_q + {3'b0, ncell};
                    phase_d = phase_q + 4'd1;
                end
            end
            StCopy: begin
                cur_we    = 1'b1;
                cur_wdata = nxt_q[idx_q];
                idx_d     = idx_q + IdxW'(1);
                if (idx_q == LastIdx) begin
                    state_d = StIdle;
                    gen_d   = gen_q + 16'd1;
                end
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= StInit;
            idx_q     <= '0;
            phase_q   <= '0;
            cnt_q     <= '0;
            timer_q   <= '0;
            gen_q     <= '0;
            lfsr_q    <= SEED;
            wrap_q    <= 1'b0;
            birth_q   <= '0;
            survive_q <= '0;
            rd_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            phase_q   <= phase_d;
            cnt_q     <= cnt_d;
            timer_q   <= timer_d;
            gen_q     <= gen_d;
            lfsr_q    <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
            wrap_q    <= wrap_d;
            birth_q   <= birth_d;
            survive_q <= survive_d;
            rd_q      <= cur_q[{rd_y_i, rd_x_i}];
        end
    end

    // Board storage is not reset: INIT always rewrites it after reset.
    always_ff @(posedge clk_i) begin
        if (cur_we) cur_q[cur_waddr] <= cur_wdata;
        if (nxt_we) nxt_q[idx_q] <= nxt_wdata;
    end

    assign rd_cell_o   = rd_q;
    assign busy_o      = (state_q != StIdle);
    assign done_o      = ((state_q == StInit) || (state_q == StCopy)) && (idx_q == LastIdx);
    assign gen_count_o = gen_q;

endmodule
